// File: rtl/key_matrix_scan.sv
// key_matrix_scan
//   Scans a 4-row x 5-column key matrix, debounces the lowest pressed key
//   code over whole frames and reports every change of the stable code as a
//   framed strobe.
//
// Parameters
//   SCAN_DIV   : clk cycles each column stays driven (>=2)
//   DEB_FRAMES : identical consecutive frame codes needed to accept a code (>=1)
//   PULSE_W    : nkpls high width and minimum low gap after it, in clk cycles (>=2)
//
// Ports
//   clk   : system clock, rising edge
//   rst   : asynchronous active-low reset
//   row_n : matrix rows, active-low, asynchronous to clk
//   col_n : column drive, exactly one bit low
//   nkv   : key code, 0 = no key, 1..20 = row*5+col+1
//   nkpls : key event strobe; its rising edge qualifies nkv
module key_matrix_scan #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_FRAMES = 4,
  parameter int PULSE_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [4:0] col_n,
  output logic [4:0] nkv,
  output logic       nkpls
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int MW = $clog2(DEB_FRAMES + 1);
  localparam int PW = (PULSE_W > 2) ? $clog2(PULSE_W) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;

  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] div;
  logic [2:0]    col, col_next;
  logic [4:0]    acc, acc_next, cand;
  logic [4:0]    prev, stable;
  logic [MW-1:0] match, match_next;
  logic          slot_end, frame_end, accept;

  state_t        state;
  logic [PW-1:0] pcnt;
  logic          pend_v;
  logic [4:0]    pend_code;

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  always_comb begin
    slot_end  = (div == DW'(SCAN_DIV - 1));
    frame_end = slot_end && (col == 3'd4);
    col_next  = (col == 3'd4) ? 3'd0 : col + 3'd1;

    // Lowest pressed row in the current column gives that column's lowest code.
    cand = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!row_s2[3-r]) cand = 5'((3 - r) * 5 + 32'(col) + 1);
    end

    acc_next = acc;
    if (cand != '0 && (acc == '0 || cand < acc)) acc_next = cand;

    if (acc_next == prev)
      match_next = (match == MW'(DEB_FRAMES)) ? match : match + MW'(1);
    else
      match_next = MW'(1);

    accept = frame_end && (match_next == MW'(DEB_FRAMES)) && (acc_next != stable);
  end

  // Column scan, frame code accumulation and debounce.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div    <= '0;
      col    <= '0;
      col_n  <= 5'b11110;
      acc    <= '0;
      prev   <= '0;
      match  <= '0;
      stable <= '0;
    end else if (slot_end) begin
      div   <= '0;
      col   <= col_next;
      col_n <= ~(5'b00001 << col_next);
      if (frame_end) begin
        acc   <= '0;
        prev  <= acc_next;
        match <= match_next;
        if (accept) stable <= acc_next;
      end else begin
        acc <= acc_next;
      end
    end else begin
      div <= div + DW'(1);
    end
  end

  // Output FSM. Every accepted code goes through the one-deep pending
  // register; IDLE consumes it, so a newer event simply overwrites it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      nkv       <= '0;
      nkpls     <= 1'b0;
      pcnt      <= '0;
      pend_v    <= 1'b0;
      pend_code <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_v) begin
            pend_v <= 1'b0;
            // A code equal to the last one sent carries no news.
            if (pend_code != nkv) begin
              nkv   <= pend_code;
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          nkpls <= 1'b1;
          pcnt  <= '0;
          state <= PULSE;
        end
        PULSE: begin
          if (pcnt == PW'(PULSE_W - 1)) begin
            nkpls <= 1'b0;
            pcnt  <= '0;
            state <= GAP;
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end
        GAP: begin
          if (pcnt == PW'(PULSE_W - 1)) begin
            pcnt  <= '0;
            state <= IDLE;
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        pend_v    <= 1'b1;
        pend_code <= acc_next;
      end
    end
  end

endmodule

// File: doc/key_matrix_scan.md
KEY_MATRIX_SCAN -- requirements
Module: key_matrix_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clk cycles each column stays driven; legal range >=2.
REQ-002 SHALL have parameter DEB_FRAMES, default 4: consecutive identical frame codes needed to accept a new key state; legal range >=1.
REQ-003 SHALL have parameter PULSE_W, default 4: nkpls high width, and minimum low gap after each pulse, in clk cycles; legal range >=2.
REQ-004 SHALL have port clk, input, 1 bit: system clock, rising edge active.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port row_n, input, 4 bits: matrix rows, active-low, externally pulled up, asynchronous to clk.
REQ-007 SHALL have port col_n, output, 5 bits: matrix column drive, exactly one bit low at any time.
REQ-008 SHALL have port nkv, output, 5 bits: key code; 0 = no key; 1..20 = row*5+col+1.
REQ-009 SHALL have port nkpls, output, 1 bit: key event strobe; the rising edge qualifies nkv.

Function
REQ-010 SHALL pass row_n through a 2-flop synchronizer before any use.
REQ-011 SHALL drive columns in the cyclic order col 0,1,2,3,4,0,...; each column is driven for exactly SCAN_DIV cycles; a full frame is 5*SCAN_DIV cycles.
REQ-012 SHALL sample the synchronized rows in the last cycle of each column slot only.
REQ-013 SHALL build a frame code over one frame: 0 if no sampled row bit was low; otherwise the lowest code among the pressed positions (multi-key: lowest code wins).
REQ-014 SHALL compare each finished frame code with the previous frame code; equal increments a match counter that saturates at DEB_FRAMES; unequal clears it to 1.
REQ-015 SHALL accept a frame code as the stable code when the match count reaches DEB_FRAMES and the code differs from the current stable code.
REQ-016 SHALL treat each stable-code change, including a change to 0 (release), as one key event; no event is generated while the code is unchanged.
REQ-017 SHALL run an output FSM with states IDLE, SETUP, PULSE and GAP.
REQ-018 IDLE: on a pending event, load nkv with the event code and go to SETUP.
REQ-019 SETUP: last one cycle with nkpls=0 and nkv already valid, then go to PULSE.
REQ-020 PULSE: hold nkpls=1 for PULSE_W cycles, then go to GAP.
REQ-021 GAP: hold nkpls=0 for PULSE_W cycles, then return to IDLE.
REQ-022 SHALL keep nkv constant from SETUP until the next SETUP.
REQ-023 SHALL store events accepted during SETUP, PULSE or GAP in a one-deep pending register; a newer event overwrites it (latest wins).
REQ-024 SHALL drop a pending event whose code equals the nkv last sent.
REQ-025 SHALL keep the scan and debounce logic running independently of the output FSM state.

Reset
REQ-026 SHALL, while rst=0, force: col_n=5'b11110, nkv=0, nkpls=0, stable code=0, match counter=0, previous frame code=0, pending event cleared, FSM=IDLE, column divider=0.
REQ-027 SHALL make a reset asserted mid-pulse drop nkpls to 0 immediately (asynchronous); a key held through reset produces a fresh event after DEB_FRAMES frames.
REQ-028 SHALL start scanning at column 0 on the first clk edge after rst is released.

Verification (SCAN_DIV=4, DEB_FRAMES=2, PULSE_W=2)
REQ-029 Scan order: rows idle high -> col_n steps 11110,11101,11011,10111,01111 every 4 cycles; nkpls stays 0.
REQ-030 Press row1/col2 held -> after 2 matching frames, nkv=8 one cycle before nkpls rises; nkpls high 2 cycles; exactly one pulse.
REQ-031 Release after REQ-030 -> after 2 frames, nkv=0 with one pulse; no further pulses.
REQ-032 Bounce: toggle row3/col3 on alternating frames -> no event; then hold it -> single event with nkv=19.
REQ-033 Multi-key: hold row0/col2 and row3/col4 -> nkv=3.
REQ-034 Back-to-back: press/release changes faster than the pulse+gap time -> at most one pulse queued; the final nkv equals the last stable code. Separately, assert rst during PULSE -> nkpls=0, nkv=0, col_n=11110 immediately.
